// File: rtl/tlb_l2_assoc.sv
// tlb_l2_assoc: set-associative second-level TLB. PARALLEL_NUM ways of the
// indexed set are compared per beat, so a search takes one or more beats.
// Entries are programmed through the cfg_* port; lookups use valid/ready.
// Optional feature macro: TLB_L2_ASSOC_MULTIHIT_EN (scan every beat and
// report more than one match as resp_multi_o instead of a hit).
module tlb_l2_assoc #(
  parameter int ADDR_WIDTH   = 32,
  parameter int SET          = 16,
  parameter int NUM_WAYS     = 8,
  parameter int PARALLEL_NUM = 4,
  parameter int PAGE_SIZE    = 4096,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic                                             req_valid_i,
  output logic                                             req_ready_o,
  input  logic [ADDR_WIDTH-1:0]                            req_addr_i,
  input  logic                                             req_rw_i,
  output logic                                             resp_valid_o,
  input  logic                                             resp_ready_i,
  output logic                                             resp_hit_o,
  output logic                                             resp_miss_o,
  output logic                                             resp_prot_o,
  output logic                                             resp_multi_o,
  output logic [ADDR_WIDTH-1:0]                            resp_addr_o,
  input  logic                                             cfg_we_i,
  input  logic [1+$clog2(NUM_WAYS)+$clog2(SET)-1:0]        cfg_addr_i,
  input  logic [31:0]                                      cfg_wdata_i,
  input  logic                                             cfg_flush_i,
  output logic                                             cfg_ready_o,
  input  logic                                             cnt_clr_i,
  output logic [CNT_WIDTH-1:0]                             hit_cnt_o,
  output logic [CNT_WIDTH-1:0]                             miss_cnt_o
);

`ifdef TLB_L2_ASSOC_MULTIHIT_EN
  localparam bit MULTIHIT_EN = 1'b1;
`else
  localparam bit MULTIHIT_EN = 1'b0;
`endif

  localparam int PAGE_BITS = $clog2(PAGE_SIZE);
  localparam int SET_BITS  = $clog2(SET);
  localparam int WAY_BITS  = $clog2(NUM_WAYS);
  localparam int VPN_W     = ADDR_WIDTH - PAGE_BITS;
  localparam int NUM_BEATS = NUM_WAYS / PARALLEL_NUM;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;

  state_t state_q, state_d;

  // Entry storage
  logic             valid_q [SET][NUM_WAYS];
  logic             rd_q    [SET][NUM_WAYS];
  logic             wr_q    [SET][NUM_WAYS];
  logic [VPN_W-1:0] vpn_q   [SET][NUM_WAYS];
  logic [VPN_W-1:0] ppn_q   [SET][NUM_WAYS];

  // Request and result registers
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rw_q;
  logic [BEAT_W-1:0]     beat_q;
  logic                  res_found_q, res_hit_q, res_prot_q, res_multi_q;
  logic [VPN_W-1:0]      res_ppn_q;

  logic [CNT_WIDTH-1:0]  hit_cnt_q, miss_cnt_q;

  // Config decode
  logic                cfg_field;
  logic [WAY_BITS-1:0] cfg_way;
  logic [SET_BITS-1:0] cfg_set;
  logic                unused_cfg_bits;

  assign cfg_field       = cfg_addr_i[0];
  assign cfg_way         = cfg_addr_i[WAY_BITS:1];
  assign cfg_set         = cfg_addr_i[WAY_BITS+SET_BITS:WAY_BITS+1];
  assign unused_cfg_bits = ^cfg_wdata_i;

  // Search datapath
  logic [VPN_W-1:0]    req_vpn;
  logic [SET_BITS-1:0] req_set;
  logic [WAY_BITS-1:0] cmp_way, sel_way;
  logic                any_m, multi_beat, perm_ok, last_beat;
  logic [VPN_W-1:0]    sel_ppn;

  assign req_vpn   = addr_q[ADDR_WIDTH-1:PAGE_BITS];
  assign req_set   = req_vpn[SET_BITS-1:0];
  assign last_beat = (beat_q == BEAT_W'(NUM_BEATS - 1));

  // Compare this beat's ways; pick the lowest-index match and flag a second one
  always_comb begin
    any_m      = 1'b0;
    multi_beat = 1'b0;
    sel_way    = '0;
    cmp_way    = '0;
    for (int unsigned p = 0; p < PARALLEL_NUM; p++) begin
      cmp_way = WAY_BITS'(32'(beat_q) * 32'(PARALLEL_NUM) + p);
      if (valid_q[req_set][cmp_way] && (vpn_q[req_set][cmp_way] == req_vpn)) begin
        if (any_m) multi_beat = 1'b1;
        else       sel_way    = cmp_way;
        any_m = 1'b1;
      end
    end
    perm_ok = rw_q ? wr_q[req_set][sel_way] : rd_q[req_set][sel_way];
    sel_ppn = ppn_q[req_set][sel_way];
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake readiness
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    cfg_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready_o = 1'b1;
        req_ready_o = !cfg_we_i && !cfg_flush_i;
        if (req_valid_i && req_ready_o) state_d = SEARCH;
      end
      SEARCH: begin
        if ((!MULTIHIT_EN && any_m) || last_beat) state_d = RESP;
      end
      RESP: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry storage: flush beats a write and only touches valid bits
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < SET; s++) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          valid_q[SET_BITS'(s)][WAY_BITS'(w)] <= 1'b0;
          rd_q[SET_BITS'(s)][WAY_BITS'(w)]    <= 1'b0;
          wr_q[SET_BITS'(s)][WAY_BITS'(w)]    <= 1'b0;
          vpn_q[SET_BITS'(s)][WAY_BITS'(w)]   <= '0;
          ppn_q[SET_BITS'(s)][WAY_BITS'(w)]   <= '0;
        end
      end
    end else if (cfg_ready_o && cfg_flush_i) begin
      for (int unsigned s = 0; s < SET; s++) begin
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          valid_q[SET_BITS'(s)][WAY_BITS'(w)] <= 1'b0;
        end
      end
    end else if (cfg_ready_o && cfg_we_i) begin
      if (!cfg_field) begin
        vpn_q[cfg_set][cfg_way]   <= cfg_wdata_i[ADDR_WIDTH-1:PAGE_BITS];
        valid_q[cfg_set][cfg_way] <= cfg_wdata_i[0];
        rd_q[cfg_set][cfg_way]    <= cfg_wdata_i[1];
        wr_q[cfg_set][cfg_way]    <= cfg_wdata_i[2];
      end else begin
        ppn_q[cfg_set][cfg_way]   <= cfg_wdata_i[ADDR_WIDTH-1:PAGE_BITS];
      end
    end
  end

  // Request capture and per-beat result accumulation
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      rw_q        <= 1'b0;
      beat_q      <= '0;
      res_found_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_prot_q  <= 1'b0;
      res_multi_q <= 1'b0;
      res_ppn_q   <= '0;
    end else if (state_q == IDLE) begin
      if (req_valid_i && req_ready_o) begin
        addr_q      <= req_addr_i;
        rw_q        <= req_rw_i;
        beat_q      <= '0;
        res_found_q <= 1'b0;
        res_hit_q   <= 1'b0;
        res_prot_q  <= 1'b0;
        res_multi_q <= 1'b0;
        res_ppn_q   <= '0;
      end
    end else if (state_q == SEARCH) begin
      beat_q <= beat_q + BEAT_W'(1);
      if (any_m && !res_found_q) begin
        res_found_q <= 1'b1;
        res_hit_q   <= perm_ok;
        res_prot_q  <= !perm_ok;
        res_ppn_q   <= sel_ppn;
      end
      // A second match anywhere in the set, earlier beat or this one
      if (MULTIHIT_EN && any_m && (res_found_q || multi_beat)) res_multi_q <= 1'b1;
    end
  end

  assign resp_valid_o = (state_q == RESP);
  assign resp_hit_o   = resp_valid_o && res_hit_q  && !res_multi_q;
  assign resp_prot_o  = resp_valid_o && res_prot_q && !res_multi_q;
`ifdef TLB_L2_ASSOC_MULTIHIT_EN
  assign resp_multi_o = resp_valid_o && res_multi_q;
`else
  assign resp_multi_o = 1'b0;
`endif
  assign resp_miss_o  = resp_valid_o && !resp_hit_o && !resp_prot_o && !resp_multi_o;
  assign resp_addr_o  = resp_hit_o ? {res_ppn_q, addr_q[PAGE_BITS-1:0]} : '0;

  // Saturating statistics; clear wins over a same-cycle increment
  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (resp_valid_o && resp_ready_i) begin
      if (resp_hit_o) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_tlb_l2_assoc.sv
// Bench for tlb_l2_assoc: directed vector table, hand-written corner
// sequences and randomized traffic checked against an entry-array model.
module tb_tlb_l2_assoc;
  localparam int AW = 32;
  localparam int NSET = 16;
  localparam int NW = 8;
  localparam int PN = 4;
  localparam int NB = NW / PN;
  localparam int CW = 6;
  localparam int CAW = 1 + 3 + 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic req_valid_i = 1'b0, req_ready_o, req_rw_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0, resp_addr_o;
  logic resp_valid_o, resp_ready_i = 1'b0;
  logic resp_hit_o, resp_miss_o, resp_prot_o, resp_multi_o;
  logic cfg_we_i = 1'b0, cfg_flush_i = 1'b0, cfg_ready_o, cnt_clr_i = 1'b0;
  logic [CAW-1:0] cfg_addr_i = '0;
  logic [31:0] cfg_wdata_i = '0;
  logic [CW-1:0] hit_cnt_o, miss_cnt_o;

  tlb_l2_assoc #(
    .ADDR_WIDTH(AW), .SET(NSET), .NUM_WAYS(NW), .PARALLEL_NUM(PN),
    .PAGE_SIZE(4096), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_rw_i(req_rw_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_hit_o(resp_hit_o), .resp_miss_o(resp_miss_o),
    .resp_prot_o(resp_prot_o), .resp_multi_o(resp_multi_o),
    .resp_addr_o(resp_addr_o),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
    .cfg_flush_i(cfg_flush_i), .cfg_ready_o(cfg_ready_o),
    .cnt_clr_i(cnt_clr_i), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: plain entry arrays and saturating counters
  bit        m_valid [NSET][NW];
  bit        m_rd    [NSET][NW];
  bit        m_wr    [NSET][NW];
  bit [19:0] m_vpn   [NSET][NW];
  bit [19:0] m_ppn   [NSET][NW];
  int        m_hits = 0;
  int        m_miss = 0;

  // status codes: 0 miss, 1 hit, 2 prot, 3 multi
  typedef struct {
    logic [31:0] addr;
    bit          rw;
    int          hold;
    int          st;
    logic [31:0] pa;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int s = 0; s < NSET; s++)
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 0; m_rd[s][w] = 0; m_wr[s][w] = 0;
        m_vpn[s][w] = '0; m_ppn[s][w] = '0;
      end
    m_hits = 0;
    m_miss = 0;
  endfunction

  function automatic void model_lookup(input logic [31:0] a, input bit rw,
                                       output int st, output logic [31:0] pa, output int lat);
    bit [19:0] vpn;
    int s, nmatch, first;
    bit ok;
    vpn = a[31:12];
    s = int'(vpn[3:0]);
    nmatch = 0;
    first = -1;
    for (int w = 0; w < NW; w++)
      if (m_valid[s][w] && m_vpn[s][w] == vpn) begin
        nmatch++;
        if (first < 0) first = w;
      end
    st = 0; pa = '0; lat = NB + 1;
    if (nmatch > 0) begin
      ok = rw ? m_wr[s][first] : m_rd[s][first];
      st = ok ? 1 : 2;
      pa = ok ? {m_ppn[s][first], a[11:0]} : 32'h0;
      lat = first / PN + 2;
    end
`ifdef TLB_L2_ASSOC_MULTIHIT_EN
    lat = NB + 1;
    if (nmatch >= 2) begin
      st = 3;
      pa = '0;
    end
`endif
  endfunction

  task automatic cfg_write(input int s, input int w, input int f, input logic [31:0] d);
    cfg_addr_i  = {4'(s), 3'(w), 1'(f)};
    cfg_wdata_i = d;
    cfg_we_i    = 1'b1;
    tick();
    cfg_we_i    = 1'b0;
    if (f == 0) begin
      m_vpn[s][w] = d[31:12]; m_valid[s][w] = d[0]; m_rd[s][w] = d[1]; m_wr[s][w] = d[2];
    end else begin
      m_ppn[s][w] = d[31:12];
    end
  endtask

  task automatic cfg_flush();
    cfg_flush_i = 1'b1;
    tick();
    cfg_flush_i = 1'b0;
    for (int s = 0; s < NSET; s++)
      for (int w = 0; w < NW; w++) m_valid[s][w] = 0;
  endtask

  // Issue one lookup from IDLE and check the response against expectations.
  // poke: drive an invalidating config write while the search is running.
  // clr: raise cnt_clr_i on the response handshake cycle.
  task automatic run_lookup(input logic [31:0] a, input bit rw, input int hold,
                            input int st, input logic [31:0] pa, input int lat,
                            input bit poke, input bit clr);
    int cyc;
    logic [3:0] exp_stat;
    exp_stat = {st == 1, st == 0, st == 2, st == 3};
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_rw_i    = rw;
    #1;
    check("req_ready_idle", req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
    cyc = 1;
    if (poke) begin
      check("cfg_ready_search", cfg_ready_o, 0);
      check("req_ready_search", req_ready_o, 0);
      cfg_addr_i  = {a[15:12], 3'd1, 1'b0};
      cfg_wdata_i = 32'h0;
      cfg_we_i    = 1'b1;
      tick();
      cfg_we_i = 1'b0;
      cyc = 2;
    end
    while (!resp_valid_o && cyc < 30) begin
      tick();
      cyc++;
    end
    check("latency", cyc, lat);
    check("status", {resp_hit_o, resp_miss_o, resp_prot_o, resp_multi_o}, exp_stat);
    check("resp_addr", resp_addr_o, pa);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", resp_valid_o, 1);
      check("hold_status", {resp_hit_o, resp_miss_o, resp_prot_o, resp_multi_o}, exp_stat);
      check("hold_addr", resp_addr_o, pa);
      check("hold_req_ready", req_ready_o, 0);
    end
    resp_ready_i = 1'b1;
    cnt_clr_i    = clr;
    tick();
    resp_ready_i = 1'b0;
    cnt_clr_i    = 1'b0;
    if (clr) begin
      m_hits = 0;
      m_miss = 0;
    end else if (st == 1) begin
      if (m_hits < CMAX) m_hits++;
    end else begin
      if (m_miss < CMAX) m_miss++;
    end
    check("resp_done", resp_valid_o, 0);
    check("hit_cnt", hit_cnt_o, m_hits);
    check("miss_cnt", miss_cnt_o, m_miss);
  endtask

  task automatic mlookup(input logic [31:0] a, input bit rw, input int hold,
                         input bit poke, input bit clr);
    int st, lat;
    logic [31:0] pa;
    model_lookup(a, rw, st, pa, lat);
    run_lookup(a, rw, hold, st, pa, lat, poke, clr);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{addr: 32'h00013123, rw: 0, hold: 0, st: 1, pa: 32'hABCDE123, lat: 2};
    tbl[1] = '{addr: 32'h00023FFF, rw: 0, hold: 1, st: 1, pa: 32'h12345FFF, lat: 3};
    tbl[2] = '{addr: 32'h00033000, rw: 0, hold: 0, st: 0, pa: 32'h0,        lat: 3};
    tbl[3] = '{addr: 32'h00013000, rw: 1, hold: 5, st: 2, pa: 32'h0,        lat: 2};
    tbl[4] = '{addr: 32'h00023ABC, rw: 1, hold: 0, st: 1, pa: 32'h12345ABC, lat: 3};
    tbl[5] = '{addr: 32'hFFFF0456, rw: 0, hold: 0, st: 2, pa: 32'h0,        lat: 2};
    tbl[6] = '{addr: 32'hFFFF0789, rw: 1, hold: 0, st: 1, pa: 32'h00001789, lat: 2};
    tbl[7] = '{addr: 32'h00107010, rw: 0, hold: 0, st: 1, pa: 32'h55555010, lat: 3};

    model_reset();
    tick();
    tick();
    check("rst_resp_valid", resp_valid_o, 0);
    check("rst_status", {resp_hit_o, resp_miss_o, resp_prot_o, resp_multi_o}, 4'b0);
    check("rst_resp_addr", resp_addr_o, 0);
    check("rst_req_ready", req_ready_o, 1);
    check("rst_cfg_ready", cfg_ready_o, 1);
    check("rst_hit_cnt", hit_cnt_o, 0);
    check("rst_miss_cnt", miss_cnt_o, 0);
    rst_i = 1'b0;
    tick();

    // Directed table
    cfg_write(3, 1, 0, (32'h00013 << 12) | 32'h3);
    cfg_write(3, 1, 1, 32'hABCDE << 12);
    cfg_write(3, 6, 0, (32'h00023 << 12) | 32'h7);
    cfg_write(3, 6, 1, 32'h12345 << 12);
    cfg_write(0, 3, 0, (32'hFFFF0 << 12) | 32'h5);
    cfg_write(0, 3, 1, 32'h00001 << 12);
    cfg_write(7, 7, 0, (32'h00107 << 12) | 32'hFF8 | 32'h3);
    cfg_write(7, 7, 1, 32'h55555FFF);
    for (int i = 0; i < 8; i++) begin
      int lat;
      lat = tbl[i].lat;
`ifdef TLB_L2_ASSOC_MULTIHIT_EN
      lat = NB + 1;
`endif
      run_lookup(tbl[i].addr, tbl[i].rw, tbl[i].hold, tbl[i].st, tbl[i].pa, lat, 1'b0, 1'b0);
    end

    // Duplicate VPN in ways 0 and 5
    cfg_write(9, 0, 0, (32'h00049 << 12) | 32'h3);
    cfg_write(9, 0, 1, 32'h11111 << 12);
    cfg_write(9, 5, 0, (32'h00049 << 12) | 32'h3);
    cfg_write(9, 5, 1, 32'h22222 << 12);
    mlookup(32'h00049ABC, 1'b0, 0, 1'b0, 1'b0);

    // Flush together with a write: flush wins, config blocks requests
    cfg_flush_i = 1'b1;
    cfg_we_i    = 1'b1;
    cfg_addr_i  = {4'd5, 3'd0, 1'b0};
    cfg_wdata_i = (32'h00055 << 12) | 32'h3;
    req_valid_i = 1'b1;
    req_addr_i  = 32'h00013123;
    #1;
    check("cfg_priority_req_ready", req_ready_o, 0);
    tick();
    cfg_flush_i = 1'b0;
    cfg_we_i    = 1'b0;
    req_valid_i = 1'b0;
    check("no_accept_on_cfg", resp_valid_o, 0);
    for (int s = 0; s < NSET; s++)
      for (int w = 0; w < NW; w++) m_valid[s][w] = 0;
    mlookup(32'h00013123, 1'b0, 0, 1'b0, 1'b0);
    mlookup(32'h00055000, 1'b0, 0, 1'b0, 1'b0);
    // VA word alone restores the hit: flush left the PPN intact
    cfg_write(3, 1, 0, (32'h00013 << 12) | 32'h3);
    mlookup(32'h00013123, 1'b0, 0, 1'b0, 1'b0);

    // Config write during SEARCH is ignored
    mlookup(32'h00013456, 1'b0, 0, 1'b1, 1'b0);
    mlookup(32'h00013789, 1'b0, 0, 1'b0, 1'b0);

    // Randomized traffic over sets 0..3 with a small VPN pool
    for (int i = 0; i < 200; i++) begin
      int r, s, w;
      logic [19:0] vpn;
      r = int'($urandom_range(0, 19));
      s = int'($urandom_range(0, 3));
      vpn = {16'h0100 + 16'($urandom_range(0, 3)), 4'(s)};
      if (r < 7) begin
        w = int'($urandom_range(0, NW - 1));
        if ($urandom_range(0, 1) == 0)
          cfg_write(s, w, 0, {vpn, 9'($urandom), 3'($urandom)});
        else
          cfg_write(s, w, 1, $urandom);
      end else if (r == 7) begin
        cfg_flush();
      end else begin
        mlookup({vpn, 12'($urandom)}, 1'($urandom), int'($urandom_range(0, 2)), 1'b0, 1'b0);
      end
    end

    // Drive both counters to saturation
    cfg_write(3, 1, 0, (32'h00013 << 12) | 32'h3);
    for (int i = 0; i < CMAX + 3; i++) mlookup(32'h00013000, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < CMAX + 3; i++) mlookup(32'h00033000, 1'b0, 0, 1'b0, 1'b0);
    check("hit_sat", hit_cnt_o, CMAX);
    check("miss_sat", miss_cnt_o, CMAX);

    // Clear on the handshake cycle wins over the increment
    mlookup(32'h00013000, 1'b0, 0, 1'b0, 1'b1);
    mlookup(32'h00013000, 1'b0, 0, 1'b0, 1'b0);

    // Reset while a search is in flight
    req_valid_i = 1'b1;
    req_addr_i  = 32'h00013123;
    req_rw_i    = 1'b0;
    tick();
    req_valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    model_reset();
    check("rst_mid_resp_valid", resp_valid_o, 0);
    check("rst_mid_req_ready", req_ready_o, 1);
    check("rst_mid_hit_cnt", hit_cnt_o, 0);
    check("rst_mid_miss_cnt", miss_cnt_o, 0);
    mlookup(32'h00013123, 1'b0, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
